// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle for the MEM-stage data memory.
// The core drives requests through the master modport; the memory block
// sits on the slave modport.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed RV32 data memory with byte/half/word access, sign/zero
// extension, error reporting and an optional zeroing sweep after reset.
// Accept edge: decode, lane write or word read. Next edge: extract and
// register the response.
module data_memory_ctrl #(
  parameter int DEPTH          = 512,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst,
  data_memory_ctrl_if.slave bus
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W = ADDR_W - 2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [WIDX_W-1:0] DEPTH_W  = WIDX_W'(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       we;
    logic       err;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } req_t;

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated so that every lane carries the right byte(s).
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Pick the byte/half at off and widen it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : 32'(b);
      SZ_HALF: return uns ? {16'h0, h} : 32'(h);
      default: return word;
    endcase
  endfunction

  logic [31:0] mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;

  logic              accept;
  logic [WIDX_W-1:0] widx;
  logic [1:0]        off;
  logic              in_range;
  logic              err;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic              rd_en;
  logic              clear_we;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_lanes;

  logic        vld_p0_q, vld_p0_d;
  req_t        req_p0_q, req_p0_d;
  logic [31:0] rd_word_p0_q;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Clear sweep sequencing and readiness.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
    ready_d     = (state_d == ST_RUN);
    init_done_d = (state_d == ST_RUN);
  end

  // Request decode and access classification.
  always_comb begin
    accept   = bus.req_valid & ready_q;
    widx     = bus.req_addr[ADDR_W-1:2];
    off      = bus.req_addr[1:0];
    in_range = (widx < DEPTH_W);
    err      = (bus.req_size == 2'b11) |
               ((bus.req_size == SZ_HALF) & off[0]) |
               ((bus.req_size == SZ_WORD) & (off != 2'b00)) |
               ~in_range;
    idx      = in_range ? widx[IDX_W-1:0] : '0;
    wr_en    = accept & bus.req_we & ~err;
    rd_en    = accept & ~bus.req_we & ~err;
    clear_we = (state_q == ST_CLEAR) & ~rst;
    wr_mask  = lane_mask(bus.req_size, off);
    wr_lanes = lane_data(bus.req_size, bus.req_wdata);
  end

  // ---- stage p0: accepted request captured alongside the RAM read ----
  always_comb begin
    vld_p0_d = accept;
    req_p0_d = req_p0_q;
    if (accept) begin
      req_p0_d.we   = bus.req_we;
      req_p0_d.err  = err;
      req_p0_d.size = bus.req_size;
      req_p0_d.uns  = bus.req_unsigned;
      req_p0_d.off  = off;
    end
  end

  // ---- stage p1: extended load data or error registered as the response ----
  always_comb begin
    rsp_valid_d = vld_p0_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (vld_p0_q) begin
      rsp_err_d   = req_p0_q.err;
      rsp_rdata_d = (req_p0_q.err | req_p0_q.we) ? 32'h0 :
                    load_extend(rd_word_p0_q, req_p0_q.size, req_p0_q.off, req_p0_q.uns);
    end
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= (ST_RESET == ST_RUN);
      vld_p0_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      vld_p0_q    <= vld_p0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request fields of the accepted access; no reset needed on data.
  always_ff @(posedge clk) begin
    req_p0_q <= req_p0_d;
  end

  // Block RAM: clear sweep or byte-lane store, plus synchronous word read.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_q] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
    if (rd_en) rd_word_p0_q <= mem[idx];
  end

  assign bus.req_ready = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed data memory for the RV32 core's MEM stage.
- Supports byte, halfword and word loads and stores with sign/zero extension.
- Requests use a valid/ready handshake; responses come back with one-cycle registered latency.
- Reports misaligned and out-of-range accesses as errors, and can self-clear after reset.

Parameters:
- DEPTH, 512, number of 32-bit words.
- ADDR_W, 32, request address width in bits (byte address).
- CLEAR_ON_RESET, 1, when 1, zero the whole array after every reset deassertion.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, taken from the low-order bytes.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid.
- init_done  out  1  1 once the block is in RUN.

Behaviour:
- Reset (async assert): state = CLEAR if CLEAR_ON_RESET, else RUN.
  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear counter=0.
  - init_done=0 when entering CLEAR; init_done=1 when entering RUN directly.
- CLEAR state:
  - Each cycle writes 0 to word[counter], then counter+1.
  - After writing word DEPTH-1, go to RUN; init_done=1 from that edge.
  - req_ready=0 throughout, so CLEAR lasts exactly DEPTH cycles.
- RUN state: req_ready=1 every cycle (no stalls). A request is accepted when req_valid && req_ready.
- Decode of accepted requests:
  - widx = req_addr[ADDR_W-1:2]; off = req_addr[1:0].
  - err = (req_size==11) | (req_size==01 && off[0]) | (req_size==10 && off!=0) | (widx >= DEPTH).
- Store, no error: write only the selected byte lanes on the accept edge.
  - Byte: lane off gets wdata[7:0].
  - Half: lanes off, off+1 get wdata[15:0].
  - Word: all four lanes.
  - Other lanes are unchanged.
- Load, no error: read the word on the accept edge and extract the byte/half at off. Extend to 32 bits by req_unsigned; word loads are not extended.
- Errors: no array write. Response has rsp_err=1, rsp_rdata=0.
- Response timing:
  - Request accepted at edge N gives rsp_valid=1 with rsp_rdata/rsp_err valid after edge N+1.
  - rsp_valid deasserts after edge N+2 unless another request was accepted at N+1.
  - Back-to-back requests give one response per cycle, in order.
  - There is no response back-pressure; the consumer must take every response.
- Load immediately after a store to the same word returns the newly written bytes (write-before-read ordering across consecutive accepts).
- Outputs hold their last values while rsp_valid=0; only rsp_valid is authoritative.
- Reset mid-operation: any pending response is dropped (rsp_valid=0) and CLEAR restarts from word 0.
  - With CLEAR_ON_RESET=0, array contents are retained across reset.
- Array has no reset apart from the CLEAR sweep; the synthesis target is block RAM.

Test Plan:
1. Reset, CLEAR_ON_RESET=1, DEPTH=512 -> req_ready=0 and init_done=0 for 512 cycles, then both 1. Word load at 0x7FC returns 0x00000000, rsp_err=0.
2. SW 0x80FF_7F01 @0x40, then back-to-back LB/LBU/LH/LHU @0x43, 0x43, 0x42, 0x42 -> responses 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF on four consecutive cycles, one cycle after each accept.
3. SB 0xAA @0x41, then LW @0x40 on the next cycle -> 0x80FFAA01; no bubble between store and load.
4. LH @0x41, SW @0x42, req_size=11 @0x0, LW @0x800 (widx 512) -> rsp_err=1 and rsp_rdata=0 for each. A following LW @0x40 shows the array unchanged.
5. Continuous req_valid for 8 cycles with mixed loads/stores -> exactly 8 rsp_valid pulses, in order, no gaps.
6. Assert rst while a load response is pending -> rsp_valid=0 immediately (async), CLEAR restarts.
   - Repeat with CLEAR_ON_RESET=0: a previously stored word reads back intact after reset.
